// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C requester arbiter: FSM encoding, field
// widths and the default watchdog limit.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } arb_state_t;

  localparam int unsigned ADDR_W          = 7;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 20000;

endpackage

// File: rtl/i2c_req_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo N. Produces a one-hot grant and the winner index.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic             w_hi_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Split search: lowest request at/above the pointer, else lowest overall (wrap).
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    o_any      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !w_hi_found && (IDX_W'(i) >= i_ptr)) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IDX_W'(i);
      end
      if (i_req[i] && !o_any) begin
        o_any    = 1'b1;
        w_lo_idx = IDX_W'(i);
      end
    end
    o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // One-hot decode of the chosen index.
  always_comb begin
    o_gnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_gnt[i] = o_any && (IDX_W'(i) == o_idx);
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among NUM_REQ requesters: round-robin arbitration,
// one captured command per grant, completion/read data returned to the
// winner, and a watchdog that aborts transactions the master never completes.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        m_ena,
  output logic                        m_rw,
  output logic [ADDR_W-1:0]           m_address,
  output logic [DATA_W-1:0]           m_data_in,
  input  logic                        m_busy,
  input  logic                        m_valid,
  input  logic [DATA_W-1:0]           m_data_out
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_m_ena;
  logic               r_m_rw;
  logic [ADDR_W-1:0]  r_m_addr;
  logic [DATA_W-1:0]  r_m_data;
  logic [TMR_W-1:0]   r_timer;

  logic [NUM_REQ-1:0] w_win_gnt;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any;
  logic               w_sel_rw;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_take;
  logic               w_tmo;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_win_gnt),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

  // Select the candidate winner's command fields for capture.
  always_comb begin
    w_sel_rw   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == IDX_W'(i)) begin
        w_sel_rw   = req_rw[i];
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic; m_valid has priority over the watchdog in LAUNCH/WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        if (m_valid) begin
          w_take      = 1'b1;
          w_state_nxt = FINISH;
        end else if (r_timer == TMR_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = FINISH;
        end else if (m_busy) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (m_valid) begin
          w_take      = 1'b1;
          w_state_nxt = FINISH;
        end else if (r_timer == TMR_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture, master drive, watchdog timer, completion pulses and pointer.
  // m_ena is registered from "staying in LAUNCH", so it trails gnt by one
  // cycle and falls the cycle after m_busy (or an early m_valid) is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_idx     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_m_ena   <= 1'b0;
      r_m_rw    <= 1'b0;
      r_m_addr  <= '0;
      r_m_data  <= '0;
      r_timer   <= '0;
    end else begin
      r_done  <= '0;
      r_err   <= 1'b0;
      r_m_ena <= (r_state == LAUNCH) && (w_state_nxt == LAUNCH);
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx    <= w_win_idx;
            r_gnt    <= w_win_gnt;
            r_m_rw   <= w_sel_rw;
            r_m_addr <= w_sel_addr;
            r_m_data <= w_sel_data;
          end
        end
        LAUNCH, WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_take || w_tmo) begin
            r_done <= r_gnt;
            r_err  <= w_tmo;
          end
          if (w_take && r_m_rw) r_rd_data <= m_data_out;
        end
        FINISH: begin
          r_gnt   <= '0;
          r_timer <= '0;
          r_ptr   <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign rd_data   = r_rd_data;
  assign m_ena     = r_m_ena;
  assign m_rw      = r_m_rw;
  assign m_address = r_m_addr;
  assign m_data_in = r_m_data;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter with a behavioural master and a
// transaction-level reference model of arbitration, completion and timeout.
module tb_i2c_req_arbiter;

  localparam int N   = 4;
  localparam int TMO = 50;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, req_rw;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt, done;
  logic           err;
  logic [7:0]     rd_data;
  logic           m_ena, m_rw;
  logic [6:0]     m_address;
  logic [7:0]     m_data_in;
  logic           m_busy, m_valid;
  logic [7:0]     m_data_out;

  always #5 clk = ~clk;

  i2c_req_arbiter #(
    .NUM_REQ (N),
    .IDX_W   (2),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .rd_data    (rd_data),
    .m_ena      (m_ena),
    .m_rw       (m_rw),
    .m_address  (m_address),
    .m_data_in  (m_data_in),
    .m_busy     (m_busy),
    .m_valid    (m_valid),
    .m_data_out (m_data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural I2C master ----------------
  logic       mst_act, mst_nb, mst_mv, stray_req, mute;
  logic [7:0] mst_md;
  int         mst_cnt, mst_cool, lat_mode;

  function automatic int pick_lat(int mode);
    case (mode)
      1:       return 2;
      2:       return 45 + int'($urandom_range(2, 0));
      3:       return 20;
      default: return int'($urandom_range(6, 0));
    endcase
  endfunction

  assign m_busy     = mst_act && !mst_nb;
  assign m_valid    = mst_mv;
  assign m_data_out = mst_md;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_act  <= 1'b0;
      mst_nb   <= 1'b0;
      mst_mv   <= 1'b0;
      mst_md   <= '0;
      mst_cnt  <= 0;
      mst_cool <= 0;
    end else begin
      mst_mv <= stray_req;
      if (mst_cool != 0) mst_cool <= mst_cool - 1;
      if (mst_act) begin
        if (mst_cnt == 0) begin
          mst_act  <= 1'b0;
          mst_cool <= 2;
          if (!mute) begin
            mst_mv <= 1'b1;
            mst_md <= 8'($urandom);
          end
        end else begin
          mst_cnt <= mst_cnt - 1;
        end
      end else if (m_ena && mst_cool == 0) begin
        mst_act <= 1'b1;
        mst_cnt <= pick_lat(lat_mode);
        mst_nb  <= (lat_mode == 0) && ($urandom_range(7, 0) == 0);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int o = 0; o < N; o++) begin
      int idx;
      idx = (p + o) % N;
      if (((r >> idx) & 1) != 0) return idx;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(int w);
    return N'(1) << w;
  endfunction

  int         ptr_m, win, k, idle_wait;
  bit         active, vseen, ready, finishing, quiet, rst_done;
  logic [7:0] vdata, rd_m;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [N-1:0] exp_gnt, exp_done;
  logic       exp_err;

  task automatic rand_fields(input int i);
    req_rw[i]          = 1'($urandom);
    req_addr[i*7 +: 7] = 7'($urandom);
    req_data[i*8 +: 8] = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_data = '0;
    stray_req = 1'b0; mute = 1'b0; lat_mode = 0;
    ptr_m = 0; win = 0; k = 0; idle_wait = 0;
    active = 0; vseen = 0; rst_done = 0; vdata = '0; rd_m = '0;
    cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", 32'({gnt, done, err, m_ena, m_rw}), 32'd0);
    check("reset_dat", 32'({m_address, m_data_in, rd_data}), 32'd0);
    for (int i = 0; i < N; i++) rand_fields(i);
    req = '1;
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mute     = (c >= 1200 && c < 1500);
      lat_mode = mute ? 1 : (c >= 1500 && c < 1800) ? 2 : (c >= 1900 && !rst_done) ? 3 : 0;
      quiet    = (c >= 1800 && c < 1900);

      // model step for the posedge that just passed
      exp_done  = '0;
      exp_err   = 1'b0;
      finishing = 0;
      ready     = (idle_wait == 0) && !active;
      if (idle_wait > 0) idle_wait--;
      if (active) begin
        k++;
        if (vseen || k == TMO) begin
          exp_done  = onehot(win);
          exp_err   = !vseen;
          if (vseen && cmd_rw) rd_m = vdata;
          active    = 0;
          finishing = 1;
          idle_wait = 1;
          ptr_m     = (win + 1) % N;
        end
      end else if (ready && req != '0) begin
        win      = rr_pick(req, ptr_m);
        active   = 1;
        k        = 0;
        cmd_rw   = ((req_rw >> win) & 1) != 0;
        cmd_addr = 7'(req_addr >> (7 * win));
        cmd_data = 8'(req_data >> (8 * win));
      end
      exp_gnt = (active || finishing) ? onehot(win) : '0;

      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("done", 32'(done), 32'(exp_done));
      check("err", 32'(err), 32'(exp_err));
      check("rd_data", 32'(rd_data), 32'(rd_m));
      if (active && k == 0) check("ena_early", 32'(m_ena), 32'd0);
      if (active && k == 1) begin
        check("ena_lat", 32'(m_ena), 32'd1);
        check("cmd_rw", 32'(m_rw), 32'(cmd_rw));
        check("cmd_addr", 32'(m_address), 32'(cmd_addr));
        check("cmd_data", 32'(m_data_in), 32'(cmd_data));
      end

      vseen = m_valid;
      vdata = m_data_out;

      // asynchronous reset in the middle of a WAIT
      if (c >= 1900 && !rst_done && active && k == 8) begin
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", 32'({gnt, done, err, m_ena, m_rw}), 32'd0);
        check("midrst_dat", 32'({m_address, m_data_in, rd_data}), 32'd0);
        @(negedge clk);
        check("midrst_nodone", 32'(done), 32'd0);
        rst_n     = 1'b1;
        active    = 0;
        idle_wait = 0;
        ptr_m     = 0;
        rd_m      = '0;
        vseen     = 0;
        rst_done  = 1;
      end

      // requester and stray-valid stimulus
      stray_req = quiet && (c % 9 == 0) && !active && idle_wait == 0 && req == '0;
      for (int i = 0; i < N; i++) begin
        if (exp_done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if (!quiet && $urandom_range(5, 0) == 0) begin
            req[i] = 1'b1;
            rand_fields(i);
          end
        end else if (active && win == i && $urandom_range(39, 0) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(9, 0) == 0) rand_fields(i);
      end
    end

    check("midrst_seen", 32'(rst_done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
